// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: synchronises rx, frames on a falling start edge and
// shifts in data on mid-bit pulses from an external baud generator it enables.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 bps_sig,
  output logic                 cnt_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_d_q;
  logic                 fall;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 cnt_start_q;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  // Flops reset high so the line looks idle and no false edge appears out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign fall = rx_d_q & ~rx_s_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (bps_sig) begin
          // A high line at mid-start-bit means the edge was a glitch.
          if (!rx_s_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (bps_sig) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) state_d = StStop;
        end
      end
      StStop: begin
        if (bps_sig) begin
          if (rx_s_q) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      cnt_start_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      cnt_start_q <= (state_d != StIdle);
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign cnt_start = cnt_start_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: baud-generator model, frame-level expectation queue and
// a per-cycle compare process, plus literal checks on the final received bytes.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       bps_sig;
  logic       bps_force;
  logic       cnt_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  uart_rx_ctrl #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .bps_sig   (bps_sig),
    .cnt_start (cnt_start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  int          bb_cnt   = 0;
  int          bit_cyc  = 5208;
  int          half_cyc = 2605;
  int          n_valid  = 0;
  int          n_err    = 0;
  logic [7:0]  model_data = 8'h00;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Baud generator model: first pulse half_cyc cycles after enable, then every bit_cyc.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!cnt_start) bb_cnt <= 0;
    else            bb_cnt <= bb_cnt + 1;
  end

  assign bps_sig = bps_force |
                   (cnt_start && bb_cnt >= half_cyc && ((bb_cnt - half_cyc) % bit_cyc) == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_data = 8'h00;
    end else begin
      check("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
      if (rx_valid || frame_err) begin
        if (rx_valid) n_valid++;
        if (frame_err) n_err++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got valid=%0b err=%0b at cycle %0d, expected none",
                   rx_valid, frame_err, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
          n_checks++;
          if (cyc < e.due - 2 || cyc > e.due + 2) begin
            n_fail++;
            $display("FAIL strobe_cycle: got %0d, expected %0d +/-2", cyc, e.due);
          end
          if (!e.is_err) model_data = e.data;
          check("cnt_start_at_strobe", {31'd0, cnt_start}, 32'd0);
        end
      end
      check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
      if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_strobe: got none by cycle %0d, expected at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Latency from the first edge that samples the start bit: 2 sync + 1 + half + 9 bits + 1.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit expect_it);
    if (expect_it)
      exp_q.push_back('{is_err: !stop, data: d,
                        due: cyc + 1 + 2 + 1 + half_cyc + 9 * bit_cyc + 1});
    rx = 1'b0;
    idle(bit_cyc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(bit_cyc);
    end
    rx = stop;
    idle(bit_cyc);
  endtask

  initial begin
    logic [7:0] rf;
    rst       = 1'b1;
    rx        = 1'b1;
    bps_force = 1'b0;
    idle(3);
    check("reset_cnt_start", {31'd0, cnt_start}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Clean frame at the full 5208-cycle bit time.
    send_frame(8'h55, 1'b1, 1'b1);
    idle(20);
    check("clean_rx_data", {24'd0, rx_data}, 32'h55);
    check("clean_count", n_valid, 1);
    check("clean_cnt_start_low", {31'd0, cnt_start}, 32'd0);

    // Glitch shorter than half a bit: rejected at the first bps_sig.
    rx = 1'b0;
    idle(100);
    check("glitch_cnt_start_high", {31'd0, cnt_start}, 32'd1);
    rx = 1'b1;
    idle(half_cyc + 20);
    check("glitch_cnt_start_low", {31'd0, cnt_start}, 32'd0);
    check("glitch_rx_data", {24'd0, rx_data}, 32'h55);

    // Shorter bit time for the remaining frames; the controller is divisor-agnostic.
    bit_cyc  = 104;
    half_cyc = 53;
    idle(10);

    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(20);
    check("b2b_rx_data", {24'd0, rx_data}, 32'h0F);
    check("b2b_count", n_valid, 3);

    // Break: stop bit held low after a good byte.
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    idle(20);
    rx = 1'b1;
    idle(3 * bit_cyc);
    check("break_rx_data", {24'd0, rx_data}, 32'h3C);
    check("break_err_count", n_err, 1);
    check("break_valid_count", n_valid, 4);

    // Reset during bit 4 of 0x96.
    rf = 8'h96;
    rx = 1'b0;
    idle(bit_cyc);
    for (int i = 0; i < 4; i++) begin
      rx = rf[i];
      idle(bit_cyc);
    end
    rx = rf[4];
    idle(bit_cyc / 2);
    #2 rst = 1'b1;
    #1;
    check("midrst_cnt_start", {31'd0, cnt_start}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3 * bit_cyc);
    check("postrst_cnt_start", {31'd0, cnt_start}, 32'd0);
    send_frame(8'hC8, 1'b1, 1'b1);
    idle(20);
    check("postrst_rx_data", {24'd0, rx_data}, 32'hC8);
    check("postrst_count", n_valid, 5);

    // Forced bps_sig pulses while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      bps_force = 1'b1;
      idle(1);
      bps_force = 1'b0;
      idle(5);
      check("idle_bps_cnt_start", {31'd0, cnt_start}, 32'd0);
    end
    idle(3 * bit_cyc);
    check("idle_bps_rx_data", {24'd0, rx_data}, 32'hC8);
    check("final_err_count", n_err, 1);
    check("final_valid_count", n_valid, 5);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller: synchronises the asynchronous serial line, detects the start bit, drives `cnt_start` to the mid-bit baud generator, and shifts in one 8N1 frame using that generator's `bps_sig` pulses. Sits directly upstream of the baud counter (which it enables) and downstream of the RX pin. Delivers a parallel byte with a one-cycle valid strobe, or a framing-error strobe, to the rest of the design.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; 1 start bit, 1 stop bit, no parity.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous active-high reset.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `bps_sig`  input  1  one-cycle pulse from the baud generator at the middle of each bit period while `cnt_start` is high.
- `cnt_start`  output  1  baud-counter enable; high for the whole frame, low in idle.
- `rx_data`  output  DATA_BITS  last correctly received byte; held until the next good frame.
- `rx_valid`  output  1  one-cycle strobe: `rx_data` updated this cycle.
- `frame_err`  output  1  one-cycle strobe: stop bit sampled low; frame discarded.

## Operation
- Input conditioning: `rx` → two flops (`rx_s`) → one more flop (`rx_d`). Falling edge = `rx_d & ~rx_s`. All three flops reset to 1, so no spurious edge leaves reset.
- States: IDLE, START, DATA, STOP. `cnt_start` is registered: 1 exactly when the state is not IDLE.
- IDLE: `bps_sig` ignored. A falling edge moves to START.
- START: on `bps_sig`, sample `rx_s`.
  - 0: go to DATA, clear bit counter.
  - 1: false start/glitch. Go to IDLE with no strobe.
- DATA: on each `bps_sig`, shift `rx_s` into the MSB of the shift register (right shift, LSB first) and increment the bit counter. After the DATA_BITS-th sample, go to STOP.
- STOP: on `bps_sig`, sample `rx_s`.
  - 1: load `rx_data` from the shift register and pulse `rx_valid`.
  - 0: pulse `frame_err`; `rx_data` is unchanged.
  - Either way, go to IDLE.
- Bit counter width: clog2(DATA_BITS+1). No wrap; it is cleared on entering DATA.
- Falling edges outside IDLE are ignored. The return to IDLE happens at mid-stop-bit, so the next start edge is caught normally (back-to-back frames supported).
- Reset, at any time including mid-frame, immediately forces:
  - state IDLE
  - `cnt_start`=0, `rx_valid`=0, `frame_err`=0
  - `rx_data`=0, shift register=0, bit counter=0
  - sync flops=1

## Timing
- Line fall to START state: `rx` low at rising edge k gives `rx_s` low after edge k+1. The edge is detected combinationally, so state=START and `cnt_start`=1 after edge k+2.
- Baud generator contract (for the bench model): first `bps_sig` 2605 cycles after `cnt_start` rises, then every 5208 cycles. `bps_sig` never occurs while `cnt_start`=0.
- `rx_valid`/`frame_err`: registered, high in the single cycle after the STOP-state `bps_sig` edge. `cnt_start` falls in that same cycle.
- `rx_data` changes only in the `rx_valid` cycle.
- `rx_valid` and `frame_err` are never high together.
- Frame latency: start edge to `rx_valid` = 2 sync cycles + 1 + 2605 + (DATA_BITS+1)×5208 + 1 clocks, i.e. ≈9.5 bit times.

## Test plan
- Clean frame 0x55 at 5208 clk/bit, bench baud model connected → exactly one `rx_valid`, `rx_data`=0x55, `frame_err` never high, `cnt_start` low after the strobe.
- Back-to-back frames 0xA3 then 0x0F, one stop bit, no idle gap → two `rx_valid` strobes ~10 bit times apart, `rx_data`=0xA3 then 0x0F.
- Glitch: `rx` low for 100 cycles then high → at the first `bps_sig` the state returns to IDLE, `cnt_start` drops, no `rx_valid`/`frame_err`, `rx_data` unchanged.
- Break: frame 0x00 with stop bit held low, after a prior good 0x3C → one `frame_err` strobe, no `rx_valid`, `rx_data` stays 0x3C.
- `rst` pulsed during bit 4 of frame 0x96 → all outputs 0 immediately and `cnt_start` low. A following clean 0xC8 frame gives `rx_valid` with `rx_data`=0xC8.
- Forced `bps_sig` pulses in IDLE with `rx`=1 → no state change, `cnt_start` stays 0, no strobes.
